// File: rtl/weight_row_fetcher_if.sv
// ----------------------------------------------------------------------------
// weight_row_fetcher_if : bank read port plus weight-beat stream
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface weight_row_fetcher_if #(
  parameter int WEIGHT_PRECISION = 5,
  parameter int ROW_WEIGHTS      = 3,
  parameter int ADDR_WIDTH       = 13
);
  localparam int ROW_WIDTH = WEIGHT_PRECISION * ROW_WEIGHTS;

  logic [1:0]                  bank_control;
  logic [ADDR_WIDTH-1:0]       bank_address;
  logic [ROW_WIDTH-1:0]        bank_rdata;
  logic                        w_valid;
  logic                        w_ready;
  logic [WEIGHT_PRECISION-1:0] w_data;
  logic                        w_last;

  modport master (
    output bank_control, bank_address, w_valid, w_data, w_last,
    input  bank_rdata, w_ready
  );

  modport slave (
    input  bank_control, bank_address, w_valid, w_data, w_last,
    output bank_rdata, w_ready
  );
endinterface

`default_nettype wire

// File: rtl/weight_row_fetcher.sv
// ----------------------------------------------------------------------------
// weight_row_fetcher : reads packed weight rows from the bank, streams weights
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module weight_row_fetcher #(
  parameter int WEIGHT_PRECISION = 5,
  parameter int ROW_WEIGHTS      = 3,
  parameter int ADDR_WIDTH       = 13,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_weights_i,
  output logic                  busy_o,
  output logic                  done_o,
  weight_row_fetcher_if.master  bus
);
  localparam int ROW_WIDTH  = WEIGHT_PRECISION * ROW_WEIGHTS;
  localparam int SLOT_WIDTH = (ROW_WEIGHTS > 1) ? $clog2(ROW_WEIGHTS) : 1;
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(ROW_WEIGHTS - 1);
  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_READ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                      state_q;
  logic [ADDR_WIDTH-1:0]       row_addr_q;
  logic [CNT_WIDTH-1:0]        remaining_q;
  logic [ROW_WIDTH-1:0]        row_buf_q;
  logic [SLOT_WIDTH-1:0]       slot_q;
  logic [1:0]                  bank_ctrl_q;
  logic [ADDR_WIDTH-1:0]       bank_addr_q;
  logic                        w_valid_q;
  logic [WEIGHT_PRECISION-1:0] w_data_q;
  logic                        w_last_q;
  logic                        busy_q;
  logic                        done_q;

  logic [ADDR_WIDTH-1:0]       row_addr_d;
  logic [CNT_WIDTH-1:0]        remaining_d;
  logic [SLOT_WIDTH-1:0]       slot_d;
  logic [WEIGHT_PRECISION-1:0] next_weight_d;

  assign row_addr_d  = row_addr_q + 1'b1;
  assign remaining_d = (remaining_q != '0) ? remaining_q - 1'b1 : '0;
  assign slot_d      = slot_q + 1'b1;

  // Weight for the following slot; slot 0 sits in the LSBs of the row.
  always_comb begin
    next_weight_d = '0;
    for (int i = 0; i < ROW_WEIGHTS; i++) begin
      if (slot_d == SLOT_WIDTH'(i)) begin
        next_weight_d = row_buf_q[i*WEIGHT_PRECISION +: WEIGHT_PRECISION];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      row_addr_q  <= '0;
      remaining_q <= '0;
      row_buf_q   <= '0;
      slot_q      <= '0;
      bank_ctrl_q <= CTRL_IDLE;
      bank_addr_q <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      w_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (num_weights_i != '0) begin
              row_addr_q  <= base_addr_i;
              remaining_q <= num_weights_i;
              bank_ctrl_q <= CTRL_READ;
              bank_addr_q <= base_addr_i;
              busy_q      <= 1'b1;
              state_q     <= S_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_REQ: begin
          bank_ctrl_q <= CTRL_IDLE;
          state_q     <= S_WAIT;
        end
        // Bank data is valid only during this cycle, so slot 0 goes straight out.
        S_WAIT: begin
          row_buf_q <= bus.bank_rdata;
          slot_q    <= '0;
          w_valid_q <= 1'b1;
          w_data_q  <= bus.bank_rdata[WEIGHT_PRECISION-1:0];
          w_last_q  <= (remaining_q == CNT_WIDTH'(1));
          state_q   <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.w_ready) begin
            remaining_q <= remaining_d;
            slot_q      <= slot_d;
            if (remaining_q == CNT_WIDTH'(1)) begin
              w_valid_q <= 1'b0;
              w_last_q  <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else if (slot_q == LAST_SLOT) begin
              w_valid_q   <= 1'b0;
              row_addr_q  <= row_addr_d;
              bank_ctrl_q <= CTRL_READ;
              bank_addr_q <= row_addr_d;
              state_q     <= S_REQ;
            end else begin
              w_data_q <= next_weight_d;
              w_last_q <= (remaining_d == CNT_WIDTH'(1));
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bank_control = bank_ctrl_q;
  assign bus.bank_address = bank_addr_q;
  assign bus.w_valid      = w_valid_q;
  assign bus.w_data       = w_data_q;
  assign bus.w_last       = w_last_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

`default_nettype wire
